// File: rtl/rename_stage_if.sv
// Decode/dispatch/commit bundle for rename_stage.
// master drives micro-ops, commits and flush; slave is the renamer.
interface rename_stage_if #(
    parameter int DESTS     = 2,
    parameter int PR_ADDR_W = 5
);
    logic                       in_valid;
    logic                       in_ready;
    logic [4*DESTS-1:0]         in_dst_arch;
    logic                       out_valid;
    logic                       out_ready;
    logic [4*DESTS-1:0]         out_dst_arch;
    logic [PR_ADDR_W*DESTS-1:0] out_dst_phys;
    logic [PR_ADDR_W*DESTS-1:0] out_old_phys;
    logic                       commit_valid;
    logic [4*DESTS-1:0]         commit_dst_arch;
    logic [PR_ADDR_W*DESTS-1:0] commit_dst_phys;
    logic [PR_ADDR_W*DESTS-1:0] commit_old_phys;
    logic                       flush;
    logic [PR_ADDR_W:0]         free_count;

    modport master (
        output in_valid, in_dst_arch, out_ready,
        output commit_valid, commit_dst_arch,
        output commit_dst_phys, commit_old_phys, flush,
        input  in_ready, out_valid, out_dst_arch,
        input  out_dst_phys, out_old_phys, free_count
    );

    modport slave (
        input  in_valid, in_dst_arch, out_ready,
        input  commit_valid, commit_dst_arch,
        input  commit_dst_phys, commit_old_phys, flush,
        output in_ready, out_valid, out_dst_arch,
        output out_dst_phys, out_old_phys, free_count
    );
endinterface

// File: rtl/rename_stage.sv
// Registered register renamer: speculative/committed RAT and free pool.
// Define RENAME_SAME_CYCLE_FREE_EN to let commit-freed regs allocate same cycle.
module rename_stage #(
    parameter int PHYS_REGS = 32,
    parameter int ARCH_REGS = 10,
    parameter int DESTS     = 2,
    parameter int PR_ADDR_W = 5
) (
    input logic           clk,
    input logic           rst,
    rename_stage_if.slave io
);
    localparam int NRAT = ARCH_REGS + 2;
    localparam int PW   = PR_ADDR_W;

    typedef logic [PW-1:0]        preg_t;
    typedef logic [PW:0]          cnt_t;
    typedef logic [PHYS_REGS-1:0] pool_t;

    function automatic pool_t init_pool();
        pool_t p;
        p = '0;
        for (int i = NRAT; i < PHYS_REGS; i++) p[i] = 1'b1;
        return p;
    endfunction

    localparam pool_t INIT_POOL = init_pool();

    function automatic cnt_t popc(input pool_t v);
        cnt_t c;
        c = '0;
        for (int i = 0; i < PHYS_REGS; i++) c = c + cnt_t'(v[i]);
        return c;
    endfunction

    function automatic logic is_ren(input logic [3:0] a);
        return (int'(a) >= 2) && (int'(a) < NRAT);
    endfunction

    preg_t spec_rat [NRAT];
    preg_t com_rat  [NRAT];
    pool_t free_pool;
    cnt_t  free_cnt_q;

    logic               ov_q;
    logic [4*DESTS-1:0] oarch_q;
    logic [PW*DESTS-1:0] ophys_q;
    logic [PW*DESTS-1:0] oold_q;

    preg_t com_nx [NRAT];
    preg_t rat_nx [NRAT];
    pool_t freed;
    pool_t avail;
    pool_t alloc;
    pool_t mapped;
    pool_t pool_nx;
    cnt_t  freed_cnt;
    cnt_t  need;
    logic [PW+1:0] have;
    logic [PW*DESTS-1:0] dphys;
    logic [PW*DESTS-1:0] ophys;
    logic [3:0] a_s;
    logic [3:0] ca_s;
    preg_t      co_s;
    preg_t      pick;
    logic       found;
    logic       accept;

    // Commit: update committed RAT and collect returned regs.
    always_comb begin
        com_nx = com_rat;
        freed  = '0;
        ca_s   = '0;
        co_s   = '0;
        for (int s = 0; s < DESTS; s++) begin
            ca_s = io.commit_dst_arch[4*s +: 4];
            co_s = io.commit_old_phys[PW*s +: PW];
            if (io.commit_valid && is_ren(ca_s)) begin
                if (int'(co_s) >= 2 && int'(co_s) < PHYS_REGS)
                    freed[co_s] = 1'b1;
                com_nx[ca_s] = io.commit_dst_phys[PW*s +: PW];
            end
        end
        freed_cnt = popc(freed);
    end

    // Slot-ordered rename against a running copy of the RAT.
    always_comb begin
        rat_nx = spec_rat;
`ifdef RENAME_SAME_CYCLE_FREE_EN
        avail = free_pool | freed;
`else
        avail = free_pool;
`endif
        alloc = '0;
        need  = '0;
        dphys = '0;
        ophys = '0;
        a_s   = '0;
        pick  = '0;
        found = 1'b0;
        for (int s = 0; s < DESTS; s++) begin
            a_s = io.in_dst_arch[4*s +: 4];
            if (is_ren(a_s)) begin
                ophys[PW*s +: PW] = rat_nx[a_s];
                pick  = '0;
                found = 1'b0;
                for (int i = 2; i < PHYS_REGS; i++) begin
                    if (!found && avail[i]) begin
                        pick  = preg_t'(i);
                        found = 1'b1;
                    end
                end
                if (found) begin
                    avail[pick] = 1'b0;
                    alloc[pick] = 1'b1;
                end
                dphys[PW*s +: PW] = pick;
                rat_nx[a_s] = pick;
                need = need + cnt_t'(1);
            end else if (a_s == 4'd1) begin
                dphys[PW*s +: PW] = preg_t'(1);
                ophys[PW*s +: PW] = preg_t'(1);
            end
        end
    end

    always_comb begin
`ifdef RENAME_SAME_CYCLE_FREE_EN
        have = {1'b0, free_cnt_q} + {1'b0, freed_cnt};
`else
        have = {1'b0, free_cnt_q};
`endif
        io.in_ready = (~ov_q | io.out_ready) & ~io.flush
                    & (have >= {1'b0, need});
        accept = io.in_valid & io.in_ready;
    end

    // Flush rebuilds the pool from whatever the committed RAT leaves unmapped.
    always_comb begin
        mapped = '0;
        if (io.flush) begin
            for (int r = 2; r < NRAT; r++) mapped[com_nx[r]] = 1'b1;
            pool_nx = ~mapped;
            pool_nx[1:0] = 2'b00;
        end else begin
            pool_nx = (free_pool | freed) & ~(accept ? alloc : '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NRAT; r++) begin
                spec_rat[r] <= preg_t'(r);
                com_rat[r]  <= preg_t'(r);
            end
            free_pool  <= INIT_POOL;
            free_cnt_q <= cnt_t'(PHYS_REGS - NRAT);
            ov_q       <= 1'b0;
            oarch_q    <= '0;
            ophys_q    <= '0;
            oold_q     <= '0;
        end else begin
            com_rat    <= com_nx;
            free_pool  <= pool_nx;
            free_cnt_q <= popc(pool_nx);
            if (io.flush) begin
                spec_rat <= com_nx;
            end else if (accept) begin
                spec_rat <= rat_nx;
            end
            if (io.flush) begin
                ov_q <= 1'b0;
            end else if (accept) begin
                ov_q    <= 1'b1;
                oarch_q <= io.in_dst_arch;
                ophys_q <= dphys;
                oold_q  <= ophys;
            end else if (io.out_ready) begin
                ov_q <= 1'b0;
            end
        end
    end

    assign io.out_valid    = ov_q;
    assign io.out_dst_arch = oarch_q;
    assign io.out_dst_phys = ophys_q;
    assign io.out_old_phys = oold_q;
    assign io.free_count   = free_cnt_q;
endmodule

// File: tb/tb_rename_stage.sv
// Directed bench for rename_stage: rename, stall, commit, flush, reset.
// Expected values are hand-computed for PHYS_REGS=32, ARCH_REGS=10.
module tb_rename_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    rename_stage_if #(.DESTS(2), .PR_ADDR_W(5)) io ();

    rename_stage #(
        .PHYS_REGS(32),
        .ARCH_REGS(10),
        .DESTS(2),
        .PR_ADDR_W(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io (io)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        io.in_valid        = 1'b0;
        io.in_dst_arch     = '0;
        io.commit_valid    = 1'b0;
        io.commit_dst_arch = '0;
        io.commit_dst_phys = '0;
        io.commit_old_phys = '0;
        io.flush           = 1'b0;
    endtask

    task automatic op(input logic [3:0] a1, input logic [3:0] a0);
        io.in_valid    = 1'b1;
        io.in_dst_arch = {a1, a0};
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        #2;
        rst = 1'b0;
        #1;
    endtask

    task automatic chk_out(input string tag,
                           input int dst, input int old, input int fc);
        chk({tag, "_valid"}, io.out_valid, 1);
        chk({tag, "_dst"}, io.out_dst_phys, dst);
        chk({tag, "_old"}, io.out_old_phys, old);
        chk({tag, "_fc"}, io.free_count, fc);
    endtask

    initial begin
        idle();
        io.out_ready = 1'b1;
        #7;
        rst = 1'b0;
        #1;
        chk("rst_valid", io.out_valid, 0);
        chk("rst_fc", io.free_count, 20);
        chk("rst_dst", io.out_dst_phys, 0);
        chk("rst_old", io.out_old_phys, 0);
        chk("rst_arch", io.out_dst_arch, 0);
        chk("rst_ready", io.in_ready, 1);

        // {3,2} -> {13,12}, old {3,2}
        op(4'd3, 4'd2);
        step();
        idle();
        chk_out("a", 13*32+12, 3*32+2, 18);
        chk("a_arch", io.out_dst_arch, 8'h32);
        step();
        chk("a_drain", io.out_valid, 0);

        // same arch twice, then a follow-up rename of 5
        do_reset();
        op(4'd5, 4'd5);
        step();
        idle();
        chk_out("b1", 13*32+12, 12*32+5, 18);
        op(4'd0, 4'd5);
        step();
        idle();
        chk_out("b2", 14, 13, 17);

        // hardwired and out-of-range arch regs
        op(4'd0, 4'd1);
        step();
        idle();
        chk_out("c1", 1, 1, 17);
        op(4'd0, 4'd5);
        step();
        idle();
        chk_out("c2", 15, 14, 16);
        op(4'd2, 4'd13);
        step();
        idle();
        chk_out("c3", 16*32, 2*32, 15);

        // exhaust pool, stall a 2-dest op, release via commit
        do_reset();
        repeat (9) begin
            op(4'd2, 4'd2);
            step();
        end
        op(4'd0, 4'd2);
        step();
        idle();
        chk_out("d_fill", 30, 29, 1);
        op(4'd4, 4'd3);
        #1;
        chk("d_stall_rdy", io.in_ready, 0);
        step();
        chk("d_stall_fc", io.free_count, 1);
        chk("d_stall_ov", io.out_valid, 0);
        io.commit_valid    = 1'b1;
        io.commit_dst_arch = {4'd0, 4'd3};
        io.commit_dst_phys = {5'd0, 5'd13};
        io.commit_old_phys = {5'd0, 5'd3};
        #1;
`ifdef RENAME_SAME_CYCLE_FREE_EN
        chk("d_cm_rdy", io.in_ready, 1);
        step();
        idle();
`else
        chk("d_cm_rdy", io.in_ready, 0);
        step();
        io.commit_valid = 1'b0;
        #1;
        chk("d_cm_fc", io.free_count, 2);
        chk("d_cm_rdy2", io.in_ready, 1);
        step();
        idle();
`endif
        chk_out("d_acc", 31*32+3, 4*32+3, 0);

        // three renames of arch 2, commit first with flush
        do_reset();
        repeat (3) begin
            op(4'd0, 4'd2);
            step();
        end
        idle();
        chk_out("e_ren", 14, 13, 17);
        io.out_ready       = 1'b0;
        io.commit_valid    = 1'b1;
        io.commit_dst_arch = {4'd0, 4'd2};
        io.commit_dst_phys = {5'd0, 5'd12};
        io.commit_old_phys = {5'd0, 5'd2};
        io.flush           = 1'b1;
        #1;
        chk("e_fl_rdy", io.in_ready, 0);
        step();
        idle();
        io.out_ready = 1'b1;
        chk("e_fl_ov", io.out_valid, 0);
        chk("e_fl_fc", io.free_count, 20);
        op(4'd0, 4'd2);
        step();
        idle();
        chk_out("e_post", 2, 12, 19);

        // output backpressure, then async reset mid-stall
        do_reset();
        io.out_ready = 1'b0;
        op(4'd3, 4'd2);
        step();
        op(4'd5, 4'd4);
        for (int k = 0; k < 4; k++) begin
            chk_out("f_hold", 13*32+12, 3*32+2, 18);
            chk("f_rdy", io.in_ready, 0);
            step();
        end
        #2;
        rst = 1'b1;
        #1;
        chk("f_rst_fc", io.free_count, 20);
        chk("f_rst_ov", io.out_valid, 0);
        chk("f_rst_dst", io.out_dst_phys, 0);
        rst = 1'b0;
        io.out_ready = 1'b1;
        op(4'd0, 4'd2);
        step();
        idle();
        chk_out("f_ident", 12, 2, 19);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
